// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the configurable UART receiver.
//   uart_rx_state_e - receiver FSM states
//   parity_e        - decoded parity mode
//   OVS / SAMPLE_*  - oversampling ratio and the three majority-vote sample ticks
//   decode_parity   - maps the 2-bit parity config onto parity_e (3 behaves as none)
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2,
        StBrkWait
    } uart_rx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    localparam int unsigned OVS        = 16;
    localparam int unsigned SAMPLE_LO  = 7;
    localparam int unsigned SAMPLE_MID = 8;
    localparam int unsigned SAMPLE_HI  = 9;

    function automatic parity_e decode_parity(input logic [1:0] cfg);
        case (cfg)
            2'd1:    return PAR_EVEN;
            2'd2:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator.
//   clk_i     - clock
//   rst_ni    - synchronous active-low reset
//   div_i     - clocks per tick minus one
//   restart_i - force the counter to 0 so the next tick lands on the following clock
//   tick_o    - one-clock tick whenever the down-counter is at 0
module uart_baud_tick #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 restart_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == '0);

    always_comb begin
        if (restart_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = div_i;
        end else begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver, 16x oversampling with 3-sample majority vote.
//   S_AXI_ACLK / S_AXI_ARESETN - clock, synchronous active-low reset
//   UART_RX                    - asynchronous serial input, idle high
//   CFG_BAUD_DIV               - clocks per oversample tick minus one
//   CFG_DATA_BITS / CFG_PARITY / CFG_STOP2 - frame format, latched at start detection
//   M_DATA / M_PERR / M_FERR / M_BREAK / M_VALID / M_READY - received beat, valid/ready
//   OVERRUN                    - one-clock pulse when a completed frame is dropped
//   BUSY                       - receiver FSM not idle
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  UART_RX,
    input  logic [DIV_WIDTH-1:0]  CFG_BAUD_DIV,
    input  logic [3:0]            CFG_DATA_BITS,
    input  logic [1:0]            CFG_PARITY,
    input  logic                  CFG_STOP2,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  M_PERR,
    output logic                  M_FERR,
    output logic                  M_BREAK,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic                  OVERRUN,
    output logic                  BUSY
);

    localparam logic [3:0] TickLast  = 4'(OVS - 1);
    localparam logic [3:0] SampleLo  = 4'(SAMPLE_LO);
    localparam logic [3:0] SampleMid = 4'(SAMPLE_MID);
    localparam logic [3:0] SampleHi  = 4'(SAMPLE_HI);
    localparam logic [3:0] MaxBits   = 4'(DATA_WIDTH);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s, rx_prev_q, rx_fall;
    logic                   tick, restart;

    uart_rx_state_e         state_q, state_d;
    logic [3:0]             tick_idx_q, tick_idx_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [1:0]             vote_q, vote_d;
    logic                   start_q, start_d;
    logic                   par_bit_q, par_bit_d;
    logic [3:0]             nbits_q, nbits_d;
    parity_e                par_mode_q, par_mode_d;
    logic                   stop2_en_q, stop2_en_d;

    logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
    logic                   m_perr_q, m_perr_d, m_ferr_q, m_ferr_d, m_break_q, m_break_d;
    logic                   m_valid_q, m_valid_d, overrun_q, overrun_d;

    logic                   maj, at_hi, at_last;
    logic                   complete, cmp_ferr, cmp_brk, cmp_perr;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], UART_RX};
    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign rx_fall = rx_prev_q & ~rx_s;
    assign restart = (state_q == StIdle) && rx_fall;

    uart_baud_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_tick (
        .clk_i     (S_AXI_ACLK),
        .rst_ni    (S_AXI_ARESETN),
        .div_i     (CFG_BAUD_DIV),
        .restart_i (restart),
        .tick_o    (tick)
    );

    // Third vote taken live at SAMPLE_HI, so the bit value is known on that tick.
    assign maj      = (vote_q[0] & vote_q[1]) | (rx_s & (vote_q[0] | vote_q[1]));
    assign at_hi    = tick && (tick_idx_q == SampleHi);
    assign at_last  = tick && (tick_idx_q == TickLast);
    assign cmp_perr = (par_mode_q != PAR_NONE) &&
                      ((^data_q ^ par_bit_q) != (par_mode_q == PAR_ODD));

    always_comb begin
        state_d    = state_q;
        tick_idx_d = tick_idx_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        vote_d     = vote_q;
        start_d    = start_q;
        par_bit_d  = par_bit_q;
        nbits_d    = nbits_q;
        par_mode_d = par_mode_q;
        stop2_en_d = stop2_en_q;
        complete   = 1'b0;
        cmp_ferr   = 1'b0;
        cmp_brk    = 1'b0;

        if (tick && state_q != StIdle && state_q != StBrkWait) begin
            tick_idx_d = tick_idx_q + 4'd1;
            if (tick_idx_q == SampleLo)  vote_d[0] = rx_s;
            if (tick_idx_q == SampleMid) vote_d[1] = rx_s;
        end

        unique case (state_q)
            StIdle: begin
                if (rx_fall) begin
                    state_d    = StStart;
                    tick_idx_d = '0;
                    bit_idx_d  = '0;
                    data_d     = '0;
                    par_bit_d  = 1'b0;
                    nbits_d    = (CFG_DATA_BITS >= 4'd5 && CFG_DATA_BITS <= MaxBits) ?
                                 CFG_DATA_BITS : MaxBits;
                    par_mode_d = decode_parity(CFG_PARITY);
                    stop2_en_d = CFG_STOP2;
                end
            end
            StStart: begin
                if (at_hi) begin
                    start_d = maj;
                end else if (at_last) begin
                    state_d = start_q ? StIdle : StData;
                end
            end
            StData: begin
                if (at_hi) begin
                    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
                        if (bit_idx_q == 4'(i)) data_d[i] = maj;
                    end
                end else if (at_last) begin
                    if (bit_idx_q == nbits_q - 4'd1) begin
                        state_d = (par_mode_q != PAR_NONE) ? StParity : StStop1;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (at_hi) begin
                    par_bit_d = maj;
                end else if (at_last) begin
                    state_d = StStop1;
                end
            end
            StStop1: begin
                // Completing mid-stop lets the next start edge be caught back to back.
                if (at_hi) begin
                    if (!(stop2_en_q && maj)) begin
                        complete = 1'b1;
                        cmp_ferr = !maj;
                        cmp_brk  = !maj && (data_q == '0) && !par_bit_q;
                    end
                end else if (at_last) begin
                    state_d = StStop2;
                end
            end
            StStop2: begin
                if (at_hi) begin
                    complete = 1'b1;
                    cmp_ferr = !maj;
                end
            end
            StBrkWait: begin
                // Count consecutive high ticks; any low sample restarts the count.
                if (tick) begin
                    if (!rx_s) begin
                        tick_idx_d = '0;
                    end else if (tick_idx_q == TickLast) begin
                        state_d    = StIdle;
                        tick_idx_d = '0;
                    end else begin
                        tick_idx_d = tick_idx_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (complete) begin
            state_d    = cmp_brk ? StBrkWait : StIdle;
            tick_idx_d = '0;
        end
    end

    always_comb begin
        m_data_d  = m_data_q;
        m_perr_d  = m_perr_q;
        m_ferr_d  = m_ferr_q;
        m_break_d = m_break_q;
        m_valid_d = m_valid_q;
        overrun_d = 1'b0;
        if (complete) begin
            if (!m_valid_q || M_READY) begin
                m_data_d  = data_q;
                m_perr_d  = cmp_perr;
                m_ferr_d  = cmp_ferr;
                m_break_d = cmp_brk;
                m_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (m_valid_q && M_READY) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            sync_q     <= '1;
            rx_prev_q  <= 1'b1;
            state_q    <= StIdle;
            tick_idx_q <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            vote_q     <= '0;
            start_q    <= 1'b0;
            par_bit_q  <= 1'b0;
            nbits_q    <= MaxBits;
            par_mode_q <= PAR_NONE;
            stop2_en_q <= 1'b0;
            m_data_q   <= '0;
            m_perr_q   <= 1'b0;
            m_ferr_q   <= 1'b0;
            m_break_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            rx_prev_q  <= rx_s;
            state_q    <= state_d;
            tick_idx_q <= tick_idx_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            vote_q     <= vote_d;
            start_q    <= start_d;
            par_bit_q  <= par_bit_d;
            nbits_q    <= nbits_d;
            par_mode_q <= par_mode_d;
            stop2_en_q <= stop2_en_d;
            m_data_q   <= m_data_d;
            m_perr_q   <= m_perr_d;
            m_ferr_q   <= m_ferr_d;
            m_break_q  <= m_break_d;
            m_valid_q  <= m_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign M_DATA  = m_data_q;
    assign M_PERR  = m_perr_q;
    assign M_FERR  = m_ferr_q;
    assign M_BREAK = m_break_q;
    assign M_VALID = m_valid_q;
    assign OVERRUN = overrun_q;
    assign BUSY    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_cfg.sv
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    localparam int unsigned DW = 9;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          rx = 1'b1;
    logic [15:0]   cfg_div = 16'd1;
    logic [3:0]    cfg_nb = 4'd8;
    logic [1:0]    cfg_par = 2'd0;
    logic          cfg_stop2 = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_perr, m_ferr, m_break, m_valid, overrun, busy;
    logic          m_ready = 1'b0;

    always #5 clk = ~clk;

    uart_rx_cfg #(
        .DATA_WIDTH  (DW),
        .DIV_WIDTH   (16),
        .SYNC_STAGES (2)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rstn),
        .UART_RX       (rx),
        .CFG_BAUD_DIV  (cfg_div),
        .CFG_DATA_BITS (cfg_nb),
        .CFG_PARITY    (cfg_par),
        .CFG_STOP2     (cfg_stop2),
        .M_DATA        (m_data),
        .M_PERR        (m_perr),
        .M_FERR        (m_ferr),
        .M_BREAK       (m_break),
        .M_VALID       (m_valid),
        .M_READY       (m_ready),
        .OVERRUN       (overrun),
        .BUSY          (busy)
    );

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } beat_t;

    beat_t exp_q[$];
    beat_t last_beat = '0;
    int    checks = 0;
    int    errors = 0;
    int    ovr_seen = 0;
    int    exp_ovr = 0;
    int    ready_mode = 2;  // 0 random, 1 hold low, 2 hold high
    int    div_v = 1;

    always @(negedge clk) begin
        case (ready_mode)
            0:       m_ready = 1'($urandom_range(0, 1));
            1:       m_ready = 1'b0;
            default: m_ready = 1'b1;
        endcase
    end

    // Compare process: every valid cycle must show the oldest expected beat.
    always begin
        @(negedge clk);
        #1;
        if (rstn) begin
            if (overrun) ovr_seen++;
            if (m_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_beat: got data=%h perr=%b ferr=%b brk=%b, want no beat",
                             m_data, m_perr, m_ferr, m_break);
                end else if ({m_data, m_perr, m_ferr, m_break} != exp_q[0]) begin
                    errors++;
                    $display("FAIL beat: got data=%h perr=%b ferr=%b brk=%b want data=%h perr=%b ferr=%b brk=%b",
                             m_data, m_perr, m_ferr, m_break,
                             exp_q[0].data, exp_q[0].perr, exp_q[0].ferr, exp_q[0].brk);
                end
                if (m_ready && exp_q.size() != 0) begin
                    last_beat = {m_data, m_perr, m_ferr, m_break};
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic int eff_bits(input logic [3:0] n);
        return (n >= 4'd5 && n <= 4'd9) ? int'(n) : int'(DW);
    endfunction

    task automatic hold_line(input logic v, input int n_ticks);
        rx = v;
        repeat (n_ticks * (div_v + 1)) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Builds the line bit sequence from the frame rules, derives the expected beat from those
    // same line bits, then drives them. Config is scrambled after the start bit.
    task automatic send_frame(input logic [8:0] word, input logic [3:0] nb_cfg,
                              input logic [1:0] par_cfg, input logic st2, input bit flip,
                              input bit s1, input bit s2, input bit expect_beat,
                              input int spike_at);
        int         nbe, t, first;
        logic [8:0] w;
        logic       pb;
        bit         par_en;
        bit         line[$];
        beat_t      b;
        nbe = eff_bits(nb_cfg);
        t = div_v + 1;
        w = '0;
        for (int i = 0; i < nbe; i++) w[i] = word[i];
        par_en = (par_cfg == 2'd1 || par_cfg == 2'd2);
        pb = (^w) ^ (par_cfg == 2'd2) ^ flip;
        line.push_back(1'b0);
        for (int i = 0; i < nbe; i++) line.push_back(w[i]);
        if (par_en) line.push_back(pb);
        line.push_back(s1);
        if (st2) line.push_back(s2);
        b.data = w;
        b.perr = par_en && (((^w) ^ pb) != (par_cfg == 2'd2));
        b.ferr = !s1 || (st2 && !s2);
        b.brk  = (w == '0) && !(par_en && pb) && !s1;
        if (expect_beat) exp_q.push_back(b);
        else exp_ovr++;
        cfg_nb = nb_cfg;
        cfg_par = par_cfg;
        cfg_stop2 = st2;
        foreach (line[i]) begin
            if (i == spike_at) begin
                first = 8 * t - t / 2;
                rx = line[i];
                repeat (first) @(negedge clk);
                rx = !line[i];
                repeat (t) @(negedge clk);
                rx = line[i];
                repeat (16 * t - first - t) @(negedge clk);
            end else begin
                rx = line[i];
                repeat (16 * t) @(negedge clk);
            end
            if (i == 0) begin
                cfg_nb = 4'($urandom);
                cfg_par = 2'($urandom);
                cfg_stop2 = 1'($urandom);
            end
        end
    endtask

    initial begin
        logic [3:0] nb;
        logic [1:0] pm;
        logic       st2, fl, s1, s2;
        int         nbe, gap;

        // Reset state
        rstn = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_flags", 32'({m_perr, m_ferr, m_break}), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // 8N1 at DIV=53
        div_v = 53;
        cfg_div = 16'd53;
        hold_line(1'b1, 20);
        send_frame(9'h0A5, 4'd8, 2'd0, 1'b0, 0, 1, 1, 1, -1);
        hold_line(1'b1, 4);
        wait_drain("8n1");
        check("8n1_beat", 32'(last_beat), 32'({9'h0A5, 3'b000}));
        check("8n1_overrun", 32'(ovr_seen), 32'd0);

        div_v = 1;
        cfg_div = 16'd1;
        hold_line(1'b1, 20);

        // 7E2 bad parity, then 7E2 with stop2 low
        send_frame(9'h03C, 4'd7, 2'd1, 1'b1, 1, 1, 1, 1, -1);
        hold_line(1'b1, 4);
        wait_drain("7e2_perr");
        check("7e2_perr_beat", 32'(last_beat), 32'({9'h03C, 3'b100}));
        send_frame(9'h03C, 4'd7, 2'd1, 1'b1, 0, 1, 0, 1, -1);
        hold_line(1'b1, 20);
        wait_drain("7e2_ferr");
        check("7e2_ferr_beat", 32'(last_beat), 32'({9'h03C, 3'b010}));

        // 5O1 then 9N1, then out-of-range width falling back to 9 bits
        send_frame(9'h01F, 4'd5, 2'd2, 1'b0, 0, 1, 1, 1, -1);
        hold_line(1'b1, 4);
        wait_drain("5o1");
        check("5o1_beat", 32'(last_beat), 32'({9'h01F, 3'b000}));
        send_frame(9'h1FF, 4'd9, 2'd0, 1'b0, 0, 1, 1, 1, -1);
        hold_line(1'b1, 4);
        wait_drain("9n1");
        check("9n1_beat", 32'(last_beat), 32'({9'h1FF, 3'b000}));
        send_frame(9'h155, 4'd15, 2'd0, 1'b0, 0, 1, 1, 1, -1);
        hold_line(1'b1, 4);
        wait_drain("oor_bits");
        check("oor_bits_beat", 32'(last_beat), 32'({9'h155, 3'b000}));

        // Short start glitch, then a frame with a one-tick spike mid data bit 2
        hold_line(1'b0, 3);
        hold_line(1'b1, 24);
        check("glitch_busy", 32'(busy), 32'd0);
        send_frame(9'h05A, 4'd8, 2'd0, 1'b0, 0, 1, 1, 1, 3);
        hold_line(1'b1, 4);
        wait_drain("spike");
        check("spike_beat", 32'(last_beat), 32'({9'h05A, 3'b000}));

        // Overrun: consumer stalled across two frames
        ready_mode = 1;
        send_frame(9'h011, 4'd8, 2'd0, 1'b0, 0, 1, 1, 1, -1);
        send_frame(9'h022, 4'd8, 2'd0, 1'b0, 0, 1, 1, 0, -1);
        hold_line(1'b1, 8);
        check("ovr_pulses", 32'(ovr_seen), 32'd1);
        check("ovr_held", 32'({m_valid, m_data}), 32'({1'b1, 9'h011}));
        ready_mode = 2;
        wait_drain("ovr");
        @(negedge clk);
        #1;
        check("ovr_valid_clear", 32'(m_valid), 32'd0);
        check("ovr_accepted", 32'(last_beat), 32'({9'h011, 3'b000}));

        // Break: line low for two frames, then needs 16 consecutive high ticks
        ready_mode = 0;
        cfg_nb = 4'd8;
        cfg_par = 2'd0;
        cfg_stop2 = 1'b0;
        exp_q.push_back({9'h000, 3'b011});
        hold_line(1'b0, 16 * 20);
        hold_line(1'b1, 8);
        check("brk_wait_busy", 32'(busy), 32'd1);
        hold_line(1'b0, 16);
        hold_line(1'b1, 8);
        check("brk_wait_rearm", 32'(busy), 32'd1);
        hold_line(1'b1, 12);
        check("brk_idle", 32'(busy), 32'd0);
        wait_drain("brk");
        check("brk_beat", 32'(last_beat), 32'({9'h000, 3'b011}));

        // Reset mid-byte
        cfg_nb = 4'd8;
        hold_line(1'b0, 16);
        hold_line(1'b1, 16);
        hold_line(1'b0, 8);
        check("midrst_busy_before", 32'(busy), 32'd1);
        rstn = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(m_valid), 32'd0);
        hold_line(1'b1, 32);
        send_frame(9'h05A, 4'd8, 2'd0, 1'b0, 0, 1, 1, 1, -1);
        hold_line(1'b1, 4);
        wait_drain("midrst");
        check("midrst_beat", 32'(last_beat), 32'({9'h05A, 3'b000}));

        // Randomized frames, random ready, random divisor
        for (int k = 0; k < 25; k++) begin
            div_v = $urandom_range(0, 2);
            cfg_div = 16'(div_v);
            hold_line(1'b1, 2);
            nb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(5, 9));
            nbe = eff_bits(nb);
            pm = 2'($urandom_range(0, 3));
            st2 = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 3) == 0);
            s1 = ($urandom_range(0, 7) != 0);
            s2 = ($urandom_range(0, 7) != 0);
            send_frame(9'($urandom_range(1, (1 << nbe) - 1)), nb, pm, st2, fl, s1, s2, 1, -1);
            gap = ((st2 && s1) ? !s2 : !s1) ? 20 : $urandom_range(0, 20);
            hold_line(1'b1, gap);
        end
        hold_line(1'b1, 4);
        wait_drain("random");
        check("final_overrun", 32'(ovr_seen), 32'(exp_ovr));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
